// File: rtl/risc_controller.sv
// Instruction-cycle sequencer for the accumulator CPU: walks eight phases per
// instruction and decodes phase/opcode/zero into the datapath strobes.
module risc_controller #(
   parameter int OPCODE_WIDTH = 3,
   parameter int PHASE_WIDTH  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero,
   output logic                    sel,
   output logic                    rd,
   output logic                    ld_ir,
   output logic                    inc_pc,
   output logic                    ld_pc,
   output logic                    ld_ac,
   output logic                    wr,
   output logic                    data_e,
   output logic                    halt,
   output logic [PHASE_WIDTH-1:0]  phase
);

   localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
   localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

   typedef enum logic [PHASE_WIDTH-1:0] {
      INST_ADDR  = PHASE_WIDTH'(0),
      INST_FETCH = PHASE_WIDTH'(1),
      INST_LOAD  = PHASE_WIDTH'(2),
      IDLE       = PHASE_WIDTH'(3),
      OP_ADDR    = PHASE_WIDTH'(4),
      OP_FETCH   = PHASE_WIDTH'(5),
      ALU_OP     = PHASE_WIDTH'(6),
      STORE      = PHASE_WIDTH'(7)
   } phase_t;

   phase_t state_q, state_d;
   logic   halted_q, halted_d;
   logic   alu_op;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
   assign phase  = state_q;

   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      sel      = 1'b0;
      rd       = 1'b0;
      ld_ir    = 1'b0;
      inc_pc   = 1'b0;
      ld_pc    = 1'b0;
      ld_ac    = 1'b0;
      wr       = 1'b0;
      data_e   = 1'b0;
      halt     = 1'b0;

      if (halted_q) begin
         // Frozen in OP_ADDR; only reset leaves this state.
         halt = 1'b1;
      end else begin
         if (state_q == OP_ADDR && opcode == OP_HLT) begin
            halted_d = 1'b1;
         end else if (state_q == STORE) begin
            state_d = INST_ADDR;
         end else begin
            state_d = phase_t'(state_q + PHASE_WIDTH'(1));
         end

         case (state_q)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (opcode == OP_HLT);
            end
            OP_FETCH: rd = alu_op;
            ALU_OP: begin
               rd     = alu_op;
               inc_pc = (opcode == OP_SKZ) && zero;
               ld_pc  = (opcode == OP_JMP);
               data_e = (opcode == OP_STO);
            end
            STORE: begin
               // data_e stays up around wr so the bus is stable for the write.
               rd     = alu_op;
               ld_ac  = alu_op;
               ld_pc  = (opcode == OP_JMP);
               wr     = (opcode == OP_STO);
               data_e = (opcode == OP_STO);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller: stimulus pushes hand-computed strobe
// vectors into a queue, a negedge monitor pops and compares them.
module tb_risc_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;

   int checks = 0;
   int errors = 0;

   // Expected entries: {phase[2:0], sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
   logic [11:0] exp_q[$];
   string       name_q[$];

   localparam logic [8:0] V_F0   = 9'b100000000;
   localparam logic [8:0] V_F1   = 9'b110000000;
   localparam logic [8:0] V_F23  = 9'b111000000;
   localparam logic [8:0] V_P4   = 9'b000100000;
   localparam logic [8:0] V_HP4  = 9'b000100001;
   localparam logic [8:0] V_HALT = 9'b000000001;
   localparam logic [8:0] V_NONE = 9'b000000000;
   localparam logic [8:0] V_RD   = 9'b010000000;
   localparam logic [8:0] V_RDAC = 9'b010001000;
   localparam logic [8:0] V_INC  = 9'b000100000;
   localparam logic [8:0] V_DE   = 9'b000000010;
   localparam logic [8:0] V_WRDE = 9'b000000110;
   localparam logic [8:0] V_LDPC = 9'b000010000;

   risc_controller #(.OPCODE_WIDTH(3), .PHASE_WIDTH(3)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
      .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are combinational and present every cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [11:0] e, a;
         string       n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                     n, a[11:9], a[8:0], e[11:9], e[8:0]);
         end
      end
   end

   task automatic cycle(input string tag, input logic [2:0] ph, input logic [8:0] v);
      exp_q.push_back({ph, v});
      name_q.push_back($sformatf("%s_ph%0d", tag, ph));
      @(posedge clk);
      #1;
   endtask

   // Runs phases 0..nph-1; opcode is junk in 0-3 and zero is inverted outside 4-6.
   task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                            input logic [8:0] e4, input logic [8:0] e5,
                            input logic [8:0] e6, input logic [8:0] e7, input int nph);
      for (int p = 0; p < nph; p++) begin
         logic [8:0] e;
         opcode = (p < 4) ? ~op : op;
         zero   = (p >= 4 && p <= 6) ? z : ~z;
         case (p)
            0: e = V_F0;
            1: e = V_F1;
            2, 3: e = V_F23;
            4: e = e4;
            5: e = e5;
            6: e = e6;
            default: e = e7;
         endcase
         cycle(tag, 3'(p), e);
      end
   endtask

   initial begin
      rst = 1'b1; opcode = 3'd2; zero = 1'b0;
      @(posedge clk); #1;
      cycle("in_reset", 3'd0, V_F0);
      rst = 1'b0;

      run_instr("add",   3'd2, 1'b0, V_P4, V_RD,   V_RD,   V_RDAC, 8);
      run_instr("skz_z1", 3'd1, 1'b1, V_P4, V_NONE, V_INC,  V_NONE, 8);
      run_instr("skz_z0", 3'd1, 1'b0, V_P4, V_NONE, V_NONE, V_NONE, 8);
      run_instr("sto",   3'd6, 1'b1, V_P4, V_NONE, V_DE,   V_WRDE, 8);
      run_instr("jmp",   3'd7, 1'b0, V_P4, V_NONE, V_LDPC, V_LDPC, 8);
      run_instr("xor",   3'd4, 1'b1, V_P4, V_RD,   V_RD,   V_RDAC, 8);

      run_instr("hlt", 3'd0, 1'b0, V_HP4, V_NONE, V_NONE, V_NONE, 5);
      for (int i = 0; i < 20; i++) begin
         opcode = 3'(i);
         zero   = i[0];
         cycle("halted", 3'd4, V_HALT);
      end
      rst = 1'b1;
      cycle("halt_rst", 3'd4, V_HALT);
      rst = 1'b0;
      run_instr("after_halt", 3'd5, 1'b0, V_P4, V_RD, V_RD, V_RDAC, 8);

      run_instr("add_mid", 3'd2, 1'b0, V_P4, V_RD, V_RD, V_RDAC, 6);
      opcode = 3'd2;
      rst = 1'b1;
      cycle("add_mid", 3'd6, V_RD);
      rst = 1'b0;
      run_instr("resume", 3'd2, 1'b0, V_P4, V_RD, V_RD, V_RDAC, 8);
      cycle("wrap", 3'd0, V_F0);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Sequencer that drives the datapath around the ALU.
- Steps a fixed 8-phase instruction cycle: fetch, decode, operand fetch, execute/store.
- Decodes the 3-bit opcode held in the instruction register and the accumulator-zero flag from the ALU.
- Produces the memory, register-load, PC and bus-enable strobes; the opcode it sees is the same opcode presented to the ALU.

Parameters:
- OPCODE_WIDTH, 3, width of the opcode input; encodings are fixed: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- PHASE_WIDTH, 3, width of the phase counter; 8 phases.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- opcode  input  OPCODE_WIDTH  instruction-register opcode field
- zero  input  1  accumulator-is-zero flag from the ALU
- sel  output  1  address mux select: 1 = PC, 0 = IR operand
- rd  output  1  memory read enable
- ld_ir  output  1  load instruction register
- inc_pc  output  1  increment PC
- ld_pc  output  1  load PC from IR operand
- ld_ac  output  1  load accumulator from ALU output
- wr  output  1  memory write strobe
- data_e  output  1  drive accumulator onto data bus
- halt  output  1  processor halted
- phase  output  PHASE_WIDTH  current phase, for debug/trace

Behaviour:
- One clock; reset is synchronous and active-high.
- State:
  - phase counter: 0..7, +1 per clock, wraps 7->0.
  - halted flag.
- Reset:
  - Sampled on the rising edge: phase<=0, halted<=0.
  - Outputs after reset follow phase 0: sel=1, all other strobes 0, halt=0.
  - Reset overrides everything, including the halted state and mid-instruction phases; no partial strobes after the reset edge.
- Strobes are a combinational decode of (phase, opcode, zero, halted); no added latency.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Phase table (unlisted strobes are 0):
  - 0 INST_ADDR: sel=1
  - 1 INST_FETCH: sel=1, rd=1
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1
  - 3 IDLE: sel=1, rd=1, ld_ir=1
  - 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT
  - 5 OP_FETCH: rd=ALUOP
  - 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO)
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO)
- Halt:
  - At the phase-4 edge with opcode==HLT, halted<=1 and phase stays at 4.
  - While halted: halt=1, phase frozen at 4, every other strobe 0 (including inc_pc).
  - Exit only via rst.
- Opcode and zero are only meaningful from phase 4 onward. Their changes in phases 0-3 do not affect outputs, except a change of opcode never alters phases 0-3 strobes.
- data_e holds through phases 6-7 for STO so the bus is stable around the wr strobe.
- zero is sampled combinationally in phase 6 only; zero toggling in phase 7 has no effect.

Test Plan:
- Reset then run: rst=1 for 2 clocks, release -> phase=0, sel=1, others 0; after 8 clocks phase wraps to 0; phase sequence 0,1,...,7,0.
- ADD (opcode=2) -> rd=1 in phases 1,2,3,5,6,7; ld_ir in 2,3; inc_pc in 4; ld_ac=1 only in 7; wr=data_e=ld_pc=0 throughout.
- SKZ (opcode=1) -> zero=1: inc_pc=1 in phases 4 and 6; zero=0: inc_pc only in 4; rd=0 in phases 5-7.
- STO (opcode=6) -> data_e=1 in 6,7; wr=1 only in 7; ld_ac=0. JMP (opcode=7) -> ld_pc=1 in 6,7 and nothing else beyond the fetch strobes.
- HLT (opcode=0) -> halt=1 in phase 4; phase frozen at 4 for 20 clocks, all strobes 0 except halt; rst=1 -> phase=0, halt=0.
- Reset mid-instruction: ADD, assert rst at phase 6 -> next edge phase=0, ld_ac never pulses; resumes a normal fetch.
